// File: rtl/csr_trap_pkg.sv
// rtl/csr_trap_pkg.sv - shared types and constants for the CSR trap sequencer
package csr_trap_pkg;

   localparam int TRAP_W = 64;

   localparam logic [11:0] CSR_MEPC   = 12'h341;
   localparam logic [11:0] CSR_MCAUSE = 12'h342;
   localparam logic [11:0] CSR_MTVAL  = 12'h343;

   localparam logic [TRAP_W-1:0] ILLEGAL_INSTR = 64'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_EPC,
      ST_WR_CAUSE,
      ST_WR_TVAL,
      ST_FLUSH,
      ST_REDIRECT
   } trap_state_e;

   typedef struct packed {
      logic [TRAP_W-1:0] cause;
      logic [TRAP_W-1:0] pc;
      logic [TRAP_W-1:0] tval;
      logic              dbg;
      logic [TRAP_W-1:0] mtvec;
   } trap_req_t;

endpackage

// File: rtl/csr_trap_target.sv
// rtl/csr_trap_target.sv - combinational trap redirect target
// Optional vectored interrupt mode: CSR_TRAP_VECTORED_EN
module csr_trap_target #(
   parameter int              XLEN           = 64,
   parameter logic [XLEN-1:0] DEBUG_EXC_ADDR = 64'h0000_0000_0000_0808
) (
   input  logic [XLEN-1:0] i_mtvec,
   input  logic [XLEN-1:0] i_cause,
   input  logic            i_dbg,
   output logic [XLEN-1:0] o_target
);

   logic [XLEN-1:0] w_base;
   logic            w_unused;

   assign w_base = {i_mtvec[XLEN-1:2], 2'b00};

`ifdef CSR_TRAP_VECTORED_EN
   assign w_unused = ^i_cause[XLEN-2:6];
`else
   assign w_unused = ^{i_cause, i_mtvec[1:0]};
`endif

   always_comb begin
      o_target = w_base;
`ifdef CSR_TRAP_VECTORED_EN
      // Only interrupts are vectored; synchronous exceptions use the base.
      if (i_mtvec[1:0] == 2'b01 && i_cause[XLEN-1])
         o_target = w_base + {{(XLEN-8){1'b0}}, i_cause[5:0], 2'b00};
`endif
      if (i_dbg)
         o_target = DEBUG_EXC_ADDR;
   end

endmodule

// File: rtl/csr_trap_sequencer.sv
// rtl/csr_trap_sequencer.sv - writes mepc/mcause/mtval, then flushes and redirects
// Optional vectored interrupt mode: CSR_TRAP_VECTORED_EN
module csr_trap_sequencer
   import csr_trap_pkg::*;
#(
   parameter int              XLEN           = 64,
   parameter logic [XLEN-1:0] DEBUG_EXC_ADDR = 64'h0000_0000_0000_0808,
   parameter int              CNT_W          = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ex_valid_i,
   input  logic [XLEN-1:0]  ex_cause_i,
   input  logic [XLEN-1:0]  ex_pc_i,
   input  logic [XLEN-1:0]  ex_tval_i,
   output logic             ex_ready_o,
   input  logic             debug_mode_i,
   input  logic [XLEN-1:0]  mtvec_i,
   output logic             csr_we_o,
   output logic [11:0]      csr_waddr_o,
   output logic [XLEN-1:0]  csr_wdata_o,
   output logic             flush_o,
   output logic             redirect_valid_o,
   output logic [XLEN-1:0]  redirect_pc_o,
   input  logic             redirect_ready_i,
   output logic             busy_o,
   output logic [CNT_W-1:0] trap_count_o
);

   trap_state_e     r_state;
   trap_state_e     w_next;
   trap_req_t       r_req;
   logic [XLEN-1:0] r_redirect_pc;
   logic [CNT_W-1:0] r_count;

   logic [XLEN-1:0] w_pc;
   logic [XLEN-1:0] w_cause;
   logic [XLEN-1:0] w_tval;
   logic [XLEN-1:0] w_mtvec;
   logic [XLEN-1:0] w_target;
   logic            w_capture;
   logic            w_accept;

   assign w_pc    = XLEN'(r_req.pc);
   assign w_cause = XLEN'(r_req.cause);
   assign w_tval  = XLEN'(r_req.tval);
   assign w_mtvec = XLEN'(r_req.mtvec);

   assign w_capture = (r_state == ST_IDLE) && ex_valid_i;
   assign w_accept  = (r_state == ST_REDIRECT) && redirect_ready_i;

   csr_trap_target #(
      .XLEN           (XLEN),
      .DEBUG_EXC_ADDR (DEBUG_EXC_ADDR)
   ) u_target (
      .i_mtvec  (w_mtvec),
      .i_cause  (w_cause),
      .i_dbg    (r_req.dbg),
      .o_target (w_target)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next           = r_state;
      csr_we_o         = 1'b0;
      csr_waddr_o      = '0;
      csr_wdata_o      = '0;
      flush_o          = 1'b0;
      redirect_valid_o = 1'b0;
      ex_ready_o       = 1'b0;
      busy_o           = 1'b1;
      case (r_state)
         ST_IDLE: begin
            ex_ready_o = 1'b1;
            busy_o     = 1'b0;
            if (ex_valid_i)
               w_next = debug_mode_i ? ST_FLUSH : ST_WR_EPC;
         end
         ST_WR_EPC: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MEPC;
            csr_wdata_o = {w_pc[XLEN-1:2], 2'b00};
            w_next      = ST_WR_CAUSE;
         end
         ST_WR_CAUSE: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MCAUSE;
            csr_wdata_o = w_cause;
            w_next      = ST_WR_TVAL;
         end
         ST_WR_TVAL: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MTVAL;
            csr_wdata_o = w_tval;
            w_next      = ST_FLUSH;
         end
         ST_FLUSH: begin
            flush_o = 1'b1;
            w_next  = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            redirect_valid_o = 1'b1;
            if (redirect_ready_i)
               w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Later states only ever read the captured copy, never the live inputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_req         <= '0;
         r_redirect_pc <= '0;
         r_count       <= '0;
      end else begin
         if (w_capture) begin
            r_req.cause <= TRAP_W'(ex_cause_i);
            r_req.pc    <= TRAP_W'(ex_pc_i);
            r_req.tval  <= TRAP_W'(ex_tval_i);
            r_req.dbg   <= debug_mode_i;
            r_req.mtvec <= TRAP_W'(mtvec_i);
         end
         if (r_state == ST_FLUSH)
            r_redirect_pc <= w_target;
         if (w_accept && (r_count != {CNT_W{1'b1}}))
            r_count <= r_count + 1'b1;
      end
   end

   assign redirect_pc_o = r_redirect_pc;
   assign trap_count_o  = r_count;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// tb/tb_csr_trap_sequencer.sv - directed self-checking bench for csr_trap_sequencer
module tb_csr_trap_sequencer;

   localparam int XLEN  = 64;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             ex_valid;
   logic [XLEN-1:0]  ex_cause;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_tval;
   logic             ex_ready;
   logic             debug_mode;
   logic [XLEN-1:0]  mtvec;
   logic             csr_we;
   logic [11:0]      csr_waddr;
   logic [XLEN-1:0]  csr_wdata;
   logic             flush;
   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic             redirect_ready;
   logic             busy;
   logic [CNT_W-1:0] trap_count;

   int n_checks = 0;
   int n_errors = 0;

   csr_trap_sequencer #(
      .XLEN  (XLEN),
      .CNT_W (CNT_W)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .ex_valid_i       (ex_valid),
      .ex_cause_i       (ex_cause),
      .ex_pc_i          (ex_pc),
      .ex_tval_i        (ex_tval),
      .ex_ready_o       (ex_ready),
      .debug_mode_i     (debug_mode),
      .mtvec_i          (mtvec),
      .csr_we_o         (csr_we),
      .csr_waddr_o      (csr_waddr),
      .csr_wdata_o      (csr_wdata),
      .flush_o          (flush),
      .redirect_valid_o (redirect_valid),
      .redirect_pc_o    (redirect_pc),
      .redirect_ready_i (redirect_ready),
      .busy_o           (busy),
      .trap_count_o     (trap_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic [63:0] c, input logic [63:0] p,
                         input logic [63:0] t, input logic [63:0] m, input logic d);
      ex_valid   = v;
      ex_cause   = c;
      ex_pc      = p;
      ex_tval    = t;
      mtvec      = m;
      debug_mode = d;
   endtask

   logic [63:0] exp_vec;

   initial begin
      rst            = 1'b1;
      redirect_ready = 1'b1;
      set_ex(1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
      tick();
      tick();
      check("rst_we", csr_we, 1'b0);
      check("rst_waddr", csr_waddr, 12'h0);
      check("rst_wdata", csr_wdata, 64'h0);
      check("rst_flush", flush, 1'b0);
      check("rst_rvalid", redirect_valid, 1'b0);
      check("rst_rpc", redirect_pc, 64'h0);
      check("rst_count", trap_count, 4'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", ex_ready, 1'b1);
      rst = 1'b0;

      // normal illegal-instruction trap
      set_ex(1'b1, 64'd2, 64'h8000_1002, 64'h7b00_27f3, 64'h8000_0100, 1'b0);
      tick();
      ex_valid = 1'b0;
      check("epc_we", csr_we, 1'b1);
      check("epc_addr", csr_waddr, 12'h341);
      check("epc_data", csr_wdata, 64'h8000_1000);
      check("epc_busy", busy, 1'b1);
      check("epc_exready", ex_ready, 1'b0);
      tick();
      check("cause_addr", csr_waddr, 12'h342);
      check("cause_data", csr_wdata, 64'd2);
      tick();
      check("tval_addr", csr_waddr, 12'h343);
      check("tval_data", csr_wdata, 64'h7b00_27f3);
      tick();
      check("n_flush", flush, 1'b1);
      check("n_flush_we", csr_we, 1'b0);
      tick();
      check("n_flush_once", flush, 1'b0);
      check("n_rvalid", redirect_valid, 1'b1);
      check("n_rpc", redirect_pc, 64'h8000_0100);
      tick();
      check("n_done_rvalid", redirect_valid, 1'b0);
      check("n_count", trap_count, 4'd1);
      check("n_done_ready", ex_ready, 1'b1);

      // debug-mode trap, new request arriving on the accepting edge
      set_ex(1'b1, 64'd2, 64'h8000_2000, 64'h0, 64'h8000_0100, 1'b1);
      tick();
      ex_valid = 1'b0;
      check("d_we", csr_we, 1'b0);
      check("d_flush", flush, 1'b1);
      tick();
      check("d_we2", csr_we, 1'b0);
      check("d_rvalid", redirect_valid, 1'b1);
      check("d_rpc", redirect_pc, 64'h808);
      set_ex(1'b1, 64'd2, 64'h8000_3004, 64'h1234, 64'h8000_0200, 1'b0);
      tick();
      check("same_edge_busy", busy, 1'b0);
      check("same_edge_ready", ex_ready, 1'b1);
      check("d_count", trap_count, 4'd2);
      tick();
      ex_valid = 1'b0;
      check("late_cap_we", csr_we, 1'b1);
      check("late_cap_data", csr_wdata, 64'h8000_3004);

      // backpressure on that trap's redirect
      redirect_ready = 1'b0;
      tick();
      tick();
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         check("bp_rvalid", redirect_valid, 1'b1);
         check("bp_rpc", redirect_pc, 64'h8000_0200);
         check("bp_exready", ex_ready, 1'b0);
         if (i == 1) set_ex(1'b1, 64'd2, 64'h9000_0000, 64'h0, 64'h0, 1'b1);
         if (i == 2) ex_valid = 1'b0;
         tick();
      end
      redirect_ready = 1'b1;
      check("bp_rvalid5", redirect_valid, 1'b1);
      check("bp_rpc5", redirect_pc, 64'h8000_0200);
      tick();
      check("bp_done_busy", busy, 1'b0);
      check("bp_count", trap_count, 4'd3);
      tick();
      check("bp_ignored_busy", busy, 1'b0);

      // reset during WR_CAUSE
      set_ex(1'b1, 64'd2, 64'h8000_1002, 64'h7b00_27f3, 64'h8000_0100, 1'b0);
      tick();
      ex_valid = 1'b0;
      tick();
      check("mr_pre_addr", csr_waddr, 12'h342);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mr_we", csr_we, 1'b0);
      check("mr_waddr", csr_waddr, 12'h0);
      check("mr_wdata", csr_wdata, 64'h0);
      check("mr_flush", flush, 1'b0);
      check("mr_rvalid", redirect_valid, 1'b0);
      check("mr_rpc", redirect_pc, 64'h0);
      check("mr_busy", busy, 1'b0);
      check("mr_ready", ex_ready, 1'b1);
      check("mr_count", trap_count, 4'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("mr_idle_we", csr_we, 1'b0);
         check("mr_idle_rvalid", redirect_valid, 1'b0);
      end

      // vectored interrupt target (mode bits ignored without the macro)
`ifdef CSR_TRAP_VECTORED_EN
      exp_vec = 64'h8000_011C;
`else
      exp_vec = 64'h8000_0100;
`endif
      set_ex(1'b1, 64'h8000_0000_0000_0007, 64'h8000_4003, 64'h0, 64'h8000_0101, 1'b0);
      tick();
      ex_valid = 1'b0;
      check("v_epc", csr_wdata, 64'h8000_4000);
      tick();
      check("v_cause", csr_wdata, 64'h8000_0000_0000_0007);
      tick();
      tick();
      tick();
      check("v_rpc", redirect_pc, exp_vec);
      tick();
      check("v_count", trap_count, 4'd1);

      // counter saturation with a 4-bit counter
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int t = 1; t <= 17; t++) begin
         set_ex(1'b1, 64'd2, 64'h0, 64'h0, 64'h0, 1'b1);
         tick();
         ex_valid = 1'b0;
         tick();
         tick();
         check("sat_count", trap_count, (t > 15) ? 64'd15 : 64'(t));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
